// File: rtl/hdvd_capture.sv
// hdvd_capture: samples pixels qualified by HD/VD, measures line length and
// frame height, locks after a run of matching frames, then streams pixels
// tagged with x/y coordinates, start-of-frame and end-of-line markers.
module hdvd_capture #(
  parameter int DATA_W      = 8,
  parameter int H_W         = 16,
  parameter int V_W         = 13,
  parameter int LOCK_FRAMES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hd_i,
  input  logic              vd_i,
  input  logic [DATA_W-1:0] pix_i,
  output logic [DATA_W-1:0] pix_o,
  output logic              pix_valid_o,
  output logic              sof_o,
  output logic              eol_o,
  output logic [H_W-1:0]    x_o,
  output logic [V_W-1:0]    y_o,
  output logic [H_W-1:0]    line_len_o,
  output logic [V_W-1:0]    frame_lines_o,
  output logic              locked_o,
  output logic              err_o
);

  localparam int MC_W = $clog2(LOCK_FRAMES + 1);

  typedef enum logic [1:0] {S_SEARCH, S_MEASURE, S_CHECK, S_LOCKED} state_t;

  // Counters hold at all-ones; reaching that value is flagged as a violation.
  function automatic logic [H_W-1:0] sat_inc_h(input logic [H_W-1:0] v);
    return (&v) ? v : v + H_W'(1);
  endfunction

  function automatic logic [V_W-1:0] sat_inc_v(input logic [V_W-1:0] v);
    return (&v) ? v : v + V_W'(1);
  endfunction

  state_t            state_q, state_d;

  logic              hd_p1, vd_p1;
  logic [DATA_W-1:0] pix_p1;
  logic              hq_p2, vd_p2;

  logic [H_W-1:0]    hcnt_q, hcnt_d;
  logic [V_W-1:0]    lcnt_q, lcnt_d;
  logic [V_W-1:0]    ycnt_q, ycnt_d;
  logic [H_W-1:0]    ref_len_q, ref_len_d;
  logic [V_W-1:0]    ref_lines_q, ref_lines_d;
  logic              len_set_q, len_set_d;
  logic [MC_W-1:0]   match_cnt_q, match_cnt_d;
  logic              out_en_q, out_en_d;
  logic              err_q, err_d;

  logic              vld_p1, sof_p1, eol_p1;
  logic [H_W-1:0]    x_p1;
  logic [V_W-1:0]    y_p1;
  logic              vld_p2, sof_p2, eol_p2;
  logic [H_W-1:0]    x_p2;
  logic [V_W-1:0]    y_p2;
  logic [DATA_W-1:0] pix_p2;

  logic              hq, hq_rise, line_end;
  logic              vd_rise, vd_fall, frame_end, frame_viol;
  logic              sat_viol, struct_viol, len_bad, frm_bad, viol;
  logic [H_W-1:0]    hpos;
  logic [V_W-1:0]    ypos;
  logic [MC_W-1:0]   mc_inc;

  // Stage 1: pin registers, plus one cycle of history for edge detection
  always_ff @(posedge clk) begin
    hd_p1  <= hd_i;
    vd_p1  <= vd_i;
    pix_p1 <= pix_i;
    hq_p2  <= hd_p1 & vd_p1;
    vd_p2  <= vd_p1;
  end

  // HD only counts inside VD, so HD activity during vertical blanking is
  // invisible and a simultaneous HD/VD rise opens the first line.
  assign hq          = hd_p1 & vd_p1;
  assign hq_rise     = hq & ~hq_p2;
  assign line_end    = ~hq & hq_p2 & vd_p1;
  assign vd_rise     = vd_p1 & ~vd_p2;
  assign vd_fall     = ~vd_p1 & vd_p2;
  assign frame_end   = vd_fall & ~hq_p2;
  assign frame_viol  = vd_fall & hq_p2;
  assign hpos        = hq_rise ? '0 : hcnt_q;
  assign ypos        = vd_rise ? '0 : ycnt_q;
  assign sat_viol    = (hq & ~hq_rise & (&hcnt_q)) | (hq_rise & ~vd_rise & (&lcnt_q));
  assign struct_viol = frame_viol | sat_viol;
  assign len_bad     = (line_end & (hcnt_q != ref_len_q)) | (hq & (hpos >= ref_len_q));
  assign frm_bad     = frame_end & (lcnt_q != ref_lines_q);
  assign viol        = struct_viol | len_bad | frm_bad;
  assign mc_inc      = match_cnt_q + MC_W'(1);

  // Line/frame measurement counters, running in every state
  always_comb begin
    hcnt_d = hcnt_q;
    lcnt_d = lcnt_q;
    ycnt_d = ycnt_q;
    if (hq) begin
      hcnt_d = sat_inc_h(hpos);
    end
    if (vd_rise) begin
      lcnt_d = hq_rise ? V_W'(1) : '0;
      ycnt_d = '0;
    end else begin
      if (hq_rise) begin
        lcnt_d = sat_inc_v(lcnt_q);
      end
      if (line_end) begin
        ycnt_d = sat_inc_v(ycnt_q);
      end
    end
  end

  // Reference capture and consecutive-match counting
  always_comb begin
    ref_len_d   = ref_len_q;
    ref_lines_d = ref_lines_q;
    len_set_d   = len_set_q;
    match_cnt_d = match_cnt_q;
    case (state_q)
      S_SEARCH: begin
        if (vd_rise) begin
          len_set_d = 1'b0;
        end
      end
      S_MEASURE: begin
        if (line_end && !len_set_q) begin
          ref_len_d = hcnt_q;
          len_set_d = 1'b1;
        end
        if (frame_end) begin
          ref_lines_d = lcnt_q;
          match_cnt_d = MC_W'(1);
        end
      end
      S_CHECK: begin
        if (frame_end && !viol) begin
          match_cnt_d = mc_inc;
        end
      end
      default: begin
      end
    endcase
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SEARCH: begin
        if (vd_rise) begin
          state_d = S_MEASURE;
        end
      end
      S_MEASURE: begin
        if (struct_viol) begin
          state_d = S_SEARCH;
        end else if (frame_end) begin
          if (!len_set_q) begin
            state_d = S_SEARCH;
          end else if (LOCK_FRAMES <= 1) begin
            state_d = S_LOCKED;
          end else begin
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (viol) begin
          state_d = S_SEARCH;
        end else if (frame_end && (mc_inc == MC_W'(LOCK_FRAMES))) begin
          state_d = S_LOCKED;
        end
      end
      S_LOCKED: begin
        if (viol) begin
          state_d = S_SEARCH;
        end
      end
      default: begin
        state_d = S_SEARCH;
      end
    endcase
  end

  // FSM outputs: output only opens at a VD rise seen while locked, so a
  // partial frame never leaks out; the violating pixel itself is dropped.
  always_comb begin
    err_d    = 1'b0;
    out_en_d = 1'b0;
    vld_p1   = 1'b0;
    if (state_q == S_LOCKED) begin
      err_d    = viol;
      out_en_d = !viol && (out_en_q || vd_rise);
      vld_p1   = hq && (out_en_q || vd_rise) && !viol;
    end
    sof_p1 = vld_p1 && (hpos == '0) && (ypos == '0);
    eol_p1 = vld_p1 && (hpos == ref_len_q - H_W'(1));
    x_p1   = vld_p1 ? hpos : '0;
    y_p1   = vld_p1 ? ypos : '0;
  end

  // FSM state and control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_SEARCH;
      hcnt_q      <= '0;
      lcnt_q      <= '0;
      ycnt_q      <= '0;
      ref_len_q   <= '0;
      ref_lines_q <= '0;
      len_set_q   <= 1'b0;
      match_cnt_q <= '0;
      out_en_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      lcnt_q      <= lcnt_d;
      ycnt_q      <= ycnt_d;
      ref_len_q   <= ref_len_d;
      ref_lines_q <= ref_lines_d;
      len_set_q   <= len_set_d;
      match_cnt_q <= match_cnt_d;
      out_en_q    <= out_en_d;
      err_q       <= err_d;
    end
  end

  // Stage 2: output markers and coordinates
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      sof_p2 <= 1'b0;
      eol_p2 <= 1'b0;
      x_p2   <= '0;
      y_p2   <= '0;
    end else begin
      vld_p2 <= vld_p1;
      sof_p2 <= sof_p1;
      eol_p2 <= eol_p1;
      x_p2   <= x_p1;
      y_p2   <= y_p1;
    end
  end

  // Stage 2: pixel data
  always_ff @(posedge clk) begin
    pix_p2 <= pix_p1;
  end

  assign pix_o         = vld_p2 ? pix_p2 : '0;
  assign pix_valid_o   = vld_p2;
  assign sof_o         = sof_p2;
  assign eol_o         = eol_p2;
  assign x_o           = x_p2;
  assign y_o           = y_p2;
  assign line_len_o    = ref_len_q;
  assign frame_lines_o = ref_lines_q;
  assign locked_o      = (state_q == S_LOCKED);
  assign err_o         = err_q;

endmodule
